// File: rtl/sdp_ram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdp_ram_arb_pkg                                              |
// | Description : Shared constants, read-tag type and round-robin helpers.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sdp_ram_arb_pkg;

    localparam int MAX_NUM_REQ    = 16;
    localparam int PERF_CNT_WIDTH = 32;
    localparam int IDX_WIDTH      = $clog2(MAX_NUM_REQ);

    typedef struct packed {
        logic                 vld;
        logic [IDX_WIDTH-1:0] id;
    } rd_tag_t;

    function automatic logic [IDX_WIDTH-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] oh);
        logic [IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NUM_REQ; i++) begin
            if (oh[i]) idx = IDX_WIDTH'(i);
        end
        return idx;
    endfunction

    // Pointer moves just past the granted requester; unchanged without a grant.
    function automatic logic [IDX_WIDTH-1:0] rr_next(input logic [IDX_WIDTH-1:0] ptr,
                                                     input logic [MAX_NUM_REQ-1:0] gnt,
                                                     input int n);
        logic [IDX_WIDTH-1:0] k;
        if (gnt == '0) return ptr;
        k = onehot_to_idx(gnt);
        return (int'(k) >= n - 1) ? '0 : k + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_ram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdp_ram_arbiter_if                                           |
// | Description : Requester-side write/read request bus of the RAM arbiter.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface sdp_ram_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [NUM_REQ-1:0]              wr_req_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   wr_addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0]   wr_data_i;
    logic [NUM_REQ*DATA_WIDTH/8-1:0] wr_byte_valid_i;
    logic [NUM_REQ-1:0]              wr_gnt_o;
    logic [NUM_REQ-1:0]              rd_req_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   rd_addr_i;
    logic [NUM_REQ-1:0]              rd_gnt_o;
    logic [NUM_REQ-1:0]              rd_valid_o;
    logic [DATA_WIDTH-1:0]           rd_data_o;

    modport slave (
        input  wr_req_i, wr_addr_i, wr_data_i, wr_byte_valid_i, rd_req_i, rd_addr_i,
        output wr_gnt_o, rd_gnt_o, rd_valid_o, rd_data_o
    );

    modport master (
        output wr_req_i, wr_addr_i, wr_data_i, wr_byte_valid_i, rd_req_i, rd_addr_i,
        input  wr_gnt_o, rd_gnt_o, rd_valid_o, rd_data_o
    );
endinterface
`default_nettype wire

// File: rtl/sdp_ram_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : N-way round-robin arbiter, combinational one-hot grant.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter
    import sdp_ram_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    input  wire logic [N-1:0] req,
    output logic      [N-1:0] gnt
);

    logic [IDX_WIDTH-1:0]   r_ptr;
    logic [MAX_NUM_REQ-1:0] w_req_ext;
    logic [MAX_NUM_REQ-1:0] w_gnt_ext;
    logic [IDX_WIDTH:0]     w_pos;
    logic                   w_hit;

    assign w_req_ext = MAX_NUM_REQ'(req);

    // Search N positions starting at the pointer, wrapping at N.
    always_comb begin
        w_gnt_ext = '0;
        w_hit     = 1'b0;
        w_pos     = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, r_ptr} + (IDX_WIDTH+1)'(k);
            if (w_pos >= (IDX_WIDTH+1)'(N)) w_pos = w_pos - (IDX_WIDTH+1)'(N);
            if (!w_hit && w_req_ext[w_pos[IDX_WIDTH-1:0]]) begin
                w_gnt_ext[w_pos[IDX_WIDTH-1:0]] = 1'b1;
                w_hit                           = 1'b1;
            end
        end
    end

    assign gnt = w_gnt_ext[N-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_ptr <= '0;
        else       r_ptr <= rr_next(r_ptr, w_gnt_ext, N);
    end

endmodule
`default_nettype wire

// File: rtl/sdp_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdp_ram_arbiter                                              |
// | Description : Round-robin sharing of one simple dual-port RAM; optional    |
// |               stall counters enabled by SDP_RAM_ARB_PERF_CNT_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdp_ram_arbiter
    import sdp_ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  wire logic                      clk_i,
    input  wire logic                      rst_i,
    sdp_ram_arbiter_if.slave               bus,
    output logic                           ram_wr_en_o,
    output logic [DATA_WIDTH-1:0]          ram_wr_data_o,
    output logic [DATA_WIDTH/8-1:0]        ram_wr_byte_valid_o,
    output logic [ADDR_WIDTH-1:0]          ram_wr_addr_o,
    output logic                           ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0]          ram_rd_addr_o,
    input  wire logic [DATA_WIDTH-1:0]     ram_rd_data_i,
    output logic [PERF_CNT_WIDTH-1:0]      perf_wr_stall_o,
    output logic [PERF_CNT_WIDTH-1:0]      perf_rd_stall_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 1 + RD_LATENCY;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "sdp_ram_arbiter: RD_LATENCY must be 1 or 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || (DATA_WIDTH % 8) != 0) begin : g_bad_geometry
        $fatal(1, "sdp_ram_arbiter: illegal NUM_REQ or DATA_WIDTH");
    end

    logic [NUM_REQ-1:0]    w_wr_gnt;
    logic [NUM_REQ-1:0]    w_rd_gnt;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [BE_WIDTH-1:0]   w_wr_be;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    rd_tag_t               w_new_tag;
    logic [NUM_REQ-1:0]    w_rd_valid;
    rd_tag_t [DEPTH-1:0]   r_tag;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (.clk_i(clk_i), .rst_i(rst_i), .req(bus.wr_req_i), .gnt(w_wr_gnt));
    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (.clk_i(clk_i), .rst_i(rst_i), .req(bus.rd_req_i), .gnt(w_rd_gnt));

    assign bus.wr_gnt_o  = w_wr_gnt;
    assign bus.rd_gnt_o  = w_rd_gnt;
    assign bus.rd_data_o = ram_rd_data_i;

    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        w_wr_be   = '0;
        w_rd_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_wr_gnt[i]) begin
                w_wr_addr = bus.wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wr_data = bus.wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_wr_be   = bus.wr_byte_valid_i[i*BE_WIDTH +: BE_WIDTH];
            end
            if (w_rd_gnt[i]) w_rd_addr = bus.rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        w_new_tag.vld = |w_rd_gnt;
        w_new_tag.id  = onehot_to_idx(MAX_NUM_REQ'(w_rd_gnt));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ram_wr_en_o         <= 1'b0;
            ram_wr_data_o       <= '0;
            ram_wr_byte_valid_o <= '0;
            ram_wr_addr_o       <= '0;
            ram_rd_en_o         <= 1'b0;
            ram_rd_addr_o       <= '0;
            r_tag               <= '0;
        end else begin
            ram_wr_en_o <= |w_wr_gnt;
            if (|w_wr_gnt) begin
                ram_wr_data_o       <= w_wr_data;
                ram_wr_byte_valid_o <= w_wr_be;
                ram_wr_addr_o       <= w_wr_addr;
            end
            // With an output register the enable must also cover the cycle
            // after sampling, so the pending stage-1 word is captured.
            ram_rd_en_o <= (|w_rd_gnt) | ((RD_LATENCY == 2) & r_tag[0].vld);
            if (|w_rd_gnt) ram_rd_addr_o <= w_rd_addr;
            r_tag <= {r_tag[DEPTH-2:0], w_new_tag};
        end
    end

    always_comb begin
        w_rd_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_tag[DEPTH-1].vld && r_tag[DEPTH-1].id == IDX_WIDTH'(i)) w_rd_valid[i] = 1'b1;
        end
    end

    assign bus.rd_valid_o = w_rd_valid;

`ifdef SDP_RAM_ARB_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] r_wr_stall;
    logic [PERF_CNT_WIDTH-1:0] r_rd_stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_stall <= '0;
            r_rd_stall <= '0;
        end else begin
            if ((|(bus.wr_req_i & ~w_wr_gnt)) && (r_wr_stall != '1)) r_wr_stall <= r_wr_stall + 1'b1;
            if ((|(bus.rd_req_i & ~w_rd_gnt)) && (r_rd_stall != '1)) r_rd_stall <= r_rd_stall + 1'b1;
        end
    end

    assign perf_wr_stall_o = r_wr_stall;
    assign perf_rd_stall_o = r_rd_stall;
`else
    assign perf_wr_stall_o = '0;
    assign perf_rd_stall_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sdp_ram_arbiter                                           |
// | Description : Bench with RD_LATENCY 1 and 2 instances against a RAM model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sdp_ram_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BW = DW / 8;
`ifdef SDP_RAM_ARB_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    wr_req  = '0;
    logic [NR-1:0]    rd_req  = '0;
    logic [NR*AW-1:0] wr_addr = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] wr_data = '0;
    logic [NR*BW-1:0] wr_be   = '0;

    logic [NR-1:0] t_wr_gnt [2];
    logic [NR-1:0] t_rd_gnt [2];
    logic [NR-1:0] t_rd_valid [2];
    logic [DW-1:0] t_rd_data [2];
    logic [31:0]   t_pw [2];
    logic [31:0]   t_pr [2];
    logic          t_ram_wr_en [2];
    logic          t_ram_rd_en [2];
    logic [AW-1:0] t_ram_rd_addr [2];

    for (genvar l = 0; l < 2; l++) begin : g_lat
        localparam int LAT = l + 1;
        sdp_ram_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        logic          ram_wr_en, ram_rd_en;
        logic [DW-1:0] ram_wr_data, ram_rd_data;
        logic [BW-1:0] ram_wr_be;
        logic [AW-1:0] ram_wr_addr, ram_rd_addr;
        logic [31:0]   pw, pr;
        logic [DW-1:0] mem [1<<AW];
        logic [DW-1:0] r1, r2;

        assign bus.wr_req_i        = wr_req;
        assign bus.wr_addr_i       = wr_addr;
        assign bus.wr_data_i       = wr_data;
        assign bus.wr_byte_valid_i = wr_be;
        assign bus.rd_req_i        = rd_req;
        assign bus.rd_addr_i       = rd_addr;

        sdp_ram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) u_dut (
            .clk_i(clk), .rst_i(rst), .bus(bus),
            .ram_wr_en_o(ram_wr_en), .ram_wr_data_o(ram_wr_data),
            .ram_wr_byte_valid_o(ram_wr_be), .ram_wr_addr_o(ram_wr_addr),
            .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr),
            .ram_rd_data_i(ram_rd_data),
            .perf_wr_stall_o(pw), .perf_rd_stall_o(pr)
        );

        // Read-first RAM; with LAT==2 the enable also advances the output register.
        always @(posedge clk) begin
            if (ram_wr_en) begin
                for (int b = 0; b < BW; b++)
                    if (ram_wr_be[b]) mem[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
            end
            if (ram_rd_en) begin
                r1 <= mem[ram_rd_addr];
                r2 <= r1;
            end
        end
        assign ram_rd_data = (LAT == 1) ? r1 : r2;

        assign t_wr_gnt[l]      = bus.wr_gnt_o;
        assign t_rd_gnt[l]      = bus.rd_gnt_o;
        assign t_rd_valid[l]    = bus.rd_valid_o;
        assign t_rd_data[l]     = bus.rd_data_o;
        assign t_pw[l]          = pw;
        assign t_pr[l]          = pr;
        assign t_ram_wr_en[l]   = ram_wr_en;
        assign t_ram_rd_en[l]   = ram_rd_en;
        assign t_ram_rd_addr[l] = ram_rd_addr;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: priority pointers, memory image, and per-cycle read history.
    int            m_wp, m_rp, cyc;
    logic [DW-1:0] m_mem [1<<AW];
    bit            h_v  [4096];
    int            h_id [4096];
    logic [DW-1:0] h_d  [4096];
    longint        e_ws, e_rs;

    function automatic int pick(input logic [NR-1:0] req, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (ptr + k) % NR;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        wr_req[i]            = 1'b1;
        wr_addr[i*AW +: AW]  = a;
        wr_data[i*DW +: DW]  = d;
        wr_be[i*BW +: BW]    = be;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        rd_req[i]           = 1'b1;
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic step();
        int wg, rg, src;
        logic [NR-1:0] ewg, erg, ev;
        logic [AW-1:0] a;
        #3;
        wg  = pick(wr_req, m_wp);
        rg  = pick(rd_req, m_rp);
        ewg = (wg >= 0) ? (NR'(1) << wg) : '0;
        erg = (rg >= 0) ? (NR'(1) << rg) : '0;
        for (int l = 0; l < 2; l++) begin
            check_value($sformatf("wr_gnt L%0d c%0d", l + 1, cyc), 64'(t_wr_gnt[l]), 64'(ewg));
            check_value($sformatf("rd_gnt L%0d c%0d", l + 1, cyc), 64'(t_rd_gnt[l]), 64'(erg));
            src = cyc - 2 - l;
            ev  = '0;
            if (src >= 0 && h_v[src]) begin
                ev = NR'(1) << h_id[src];
                check_value($sformatf("rd_data L%0d c%0d", l + 1, cyc), 64'(t_rd_data[l]), 64'(h_d[src]));
            end
            check_value($sformatf("rd_valid L%0d c%0d", l + 1, cyc), 64'(t_rd_valid[l]), 64'(ev));
            check_value($sformatf("perf_wr L%0d c%0d", l + 1, cyc), 64'(t_pw[l]), PERF_EN ? 64'(e_ws) : 64'd0);
            check_value($sformatf("perf_rd L%0d c%0d", l + 1, cyc), 64'(t_pr[l]), PERF_EN ? 64'(e_rs) : 64'd0);
        end
        // A read granted together with a write sees the old word.
        h_v[cyc] = (rg >= 0);
        if (rg >= 0) begin
            h_id[cyc] = rg;
            h_d[cyc]  = m_mem[rd_addr[rg*AW +: AW]];
        end
        if (wg >= 0) begin
            a = wr_addr[wg*AW +: AW];
            for (int b = 0; b < BW; b++)
                if (wr_be[wg*BW + b]) m_mem[a][b*8 +: 8] = wr_data[wg*DW + b*8 +: 8];
            m_wp = (wg + 1) % NR;
        end
        if (rg >= 0) m_rp = (rg + 1) % NR;
        if ((wr_req & ~ewg) != '0) e_ws++;
        if ((rd_req & ~erg) != '0) e_rs++;
        cyc++;
        @(posedge clk);
        #1;
        if (wg >= 0) wr_req[wg] = 1'b0;
        if (rg >= 0) rd_req[rg] = 1'b0;
    endtask

    task automatic do_reset();
        wr_req = '0;
        rd_req = '0;
        rst    = 1'b1;
        #1;
        for (int l = 0; l < 2; l++) begin
            check_value($sformatf("rst rd_valid L%0d", l + 1), 64'(t_rd_valid[l]), 64'd0);
            check_value($sformatf("rst ram_wr_en L%0d", l + 1), 64'(t_ram_wr_en[l]), 64'd0);
            check_value($sformatf("rst ram_rd_en L%0d", l + 1), 64'(t_ram_rd_en[l]), 64'd0);
            check_value($sformatf("rst ram_rd_addr L%0d", l + 1), 64'(t_ram_rd_addr[l]), 64'd0);
            check_value($sformatf("rst perf_wr L%0d", l + 1), 64'(t_pw[l]), 64'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_wp = 0;
        m_rp = 0;
        e_ws = 0;
        e_rs = 0;
        for (int i = 0; i < cyc; i++) h_v[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int nxt [NR];
        cyc = 0;
        do_reset();

        // All four write at once, then read back.
        for (int i = 0; i < NR; i++) set_wr(i, 8'h10 + AW'(i), 32'hA0 + DW'(i), 4'hF);
        idle(4);
        for (int i = 0; i < NR; i++) set_rd(i, 8'h10 + AW'(i));
        idle(4);
        idle(3);

        // Requesters 1 and 3 hold read requests continuously.
        for (int n = 0; n < 8; n++) begin
            set_rd(1, 8'h11);
            set_rd(3, 8'h13);
            step();
        end
        rd_req = '0;
        idle(3);

        // Preload 0..7, then back-to-back reads.
        for (int i = 0; i < NR; i++) set_wr(i, AW'(i), DW'(i), 4'hF);
        idle(4);
        for (int i = 0; i < NR; i++) set_wr(i, AW'(i + 4), DW'(i + 4), 4'hF);
        idle(4);
        for (int i = 0; i < NR; i++) nxt[i] = 0;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!rd_req[i] && nxt[i] < 2) begin
                    set_rd(i, AW'(i + 4 * nxt[i]));
                    nxt[i]++;
                end
            end
            step();
        end
        idle(4);

        // Byte-enable merge and same-cycle write/read hazard.
        set_wr(0, 8'h20, 32'h1111_1111, 4'hF);
        idle(2);
        set_wr(0, 8'h20, 32'hDEAD_BEEF, 4'b0101);
        set_rd(0, 8'h20);
        step();
        set_rd(0, 8'h20);
        step();
        idle(4);

        // Reset with two reads in flight.
        set_rd(0, 8'h10);
        set_rd(1, 8'h11);
        idle(2);
        do_reset();
        for (int i = 0; i < NR; i++) set_rd(i, 8'h10 + AW'(i));
        idle(7);

        // Four simultaneous writers for the stall counter.
        for (int i = 0; i < NR; i++) set_wr(i, 8'h40 + AW'(i), $urandom, 4'hF);
        idle(6);

        // Randomised traffic over a pre-written window.
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < NR; i++) set_wr(i, 8'h30 + AW'(4 * j + i), $urandom, 4'hF);
            idle(4);
        end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!wr_req[i] && $urandom_range(2) == 0)
                    set_wr(i, 8'h30 + AW'($urandom_range(15)), $urandom, BW'($urandom_range(15)));
                else if (wr_req[i] && $urandom_range(15) == 0)
                    wr_req[i] = 1'b0;
                if (!rd_req[i] && $urandom_range(2) == 0)
                    set_rd(i, 8'h30 + AW'($urandom_range(15)));
                else if (rd_req[i] && $urandom_range(15) == 0)
                    rd_req[i] = 1'b0;
            end
            step();
        end
        wr_req = '0;
        rd_req = '0;
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdp_ram_arbiter.md
Name: sdp_ram_arbiter

Overview:
- Round-robin arbiter sharing one simple dual-port RAM instance between NUM_REQ requesters, single clock domain.
- Write port and read port are arbitrated independently; at most one write and one read are issued per cycle.
- Read responses are routed back to the originating requester by an ID pipeline matched to the RAM read latency.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, RAM word width; must be a multiple of 8.
- ADDR_WIDTH, 8, RAM address width.
- RD_LATENCY, 1, RAM read latency in cycles from sampled rd_en to data: 1 (no output register) or 2 (output register). Any other value fails elaboration with $fatal.

Ports:
- clk_i  in  1  clock for arbiter and RAM.
- rst_i  in  1  asynchronous, active-high reset.
- wr_req_i  in  NUM_REQ  per-requester write request.
- wr_addr_i  in  NUM_REQ*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wr_data_i  in  NUM_REQ*DATA_WIDTH  write data, sliced the same way.
- wr_byte_valid_i  in  NUM_REQ*DATA_WIDTH/8  byte enables, sliced the same way.
- wr_gnt_o  out  NUM_REQ  one-hot write grant.
- rd_req_i  in  NUM_REQ  per-requester read request.
- rd_addr_i  in  NUM_REQ*ADDR_WIDTH  read address, sliced the same way.
- rd_gnt_o  out  NUM_REQ  one-hot read grant.
- rd_valid_o  out  NUM_REQ  one-hot read-response valid.
- rd_data_o  out  DATA_WIDTH  read response data, shared by all requesters.
- ram_wr_en_o, ram_wr_data_o, ram_wr_byte_valid_o, ram_wr_addr_o  out  1/DATA_WIDTH/DATA_WIDTH/8/ADDR_WIDTH  RAM write port.
- ram_rd_en_o, ram_rd_addr_o  out  1/ADDR_WIDTH  RAM read port.
- ram_rd_data_i  in  DATA_WIDTH  RAM read data.
- perf_wr_stall_o, perf_rd_stall_o  out  32 each  stall counters; see Optional Feature.

Behaviour:
- Reset values:
  - All ram_* outputs are 0.
  - rd_valid_o is 0; perf counters are 0.
  - Both priority pointers are 0.
  - ID pipeline valid bits are cleared.
- Grant logic:
  - wr_gnt_o and rd_gnt_o are combinational from the request inputs and the registered priority pointer.
  - A grant is never asserted without its request.
  - A request is consumed in the cycle its grant is high.
  - The requester holds req, addr, data and byte enables stable until granted.
  - Dropping req before grant is legal.
- Round robin: the search starts at the pointer, modulo NUM_REQ. After granting k, the pointer moves to (k+1) mod NUM_REQ. With no grant, the pointer is unchanged.
- Write path: a grant in cycle c registers ram_wr_* at the end of c. ram_wr_en_o is high for exactly one cycle per grant. The RAM updates at the end of c+1.
- Read path:
  - A grant in cycle c registers ram_rd_addr_o and ram_rd_en_o=1 at the end of c.
  - The requester ID enters a shift pipeline of depth 1+RD_LATENCY.
  - rd_valid_o[id] is asserted in cycle c+1+RD_LATENCY, for one cycle.
  - rd_data_o = ram_rd_data_i combinationally.
  - Back-to-back reads are accepted every cycle, for full throughput.
- RD_LATENCY=2: ram_rd_en_o must also be high in every cycle where stage-1 data is pending, so the RAM output register captures it. ram_rd_addr_o holds its last value when no new read is issued.
- rd_data_o is don't-care when rd_valid_o==0.
- Hazard, write and read to the same address granted in the same cycle: the read returns old data.
- Hazard, read granted in a later cycle than the write: the read returns new data.
- Simultaneous write and read grants to the same or different requesters are independent.
- Reset asserted mid-operation: in-flight reads are dropped, and no rd_valid_o pulse appears after reset. A write registered but not yet committed to the RAM is lost.

Optional Feature:
- Macro: SDP_RAM_ARB_PERF_CNT_EN.
- Defined:
  - perf_wr_stall_o increments by 1 each cycle in which (wr_req_i & ~wr_gnt_o) != 0.
  - perf_rd_stall_o behaves the same way for the read side.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are inferred. The port list is identical in both builds.

Decomposition:
- Package sdp_ram_arb_pkg holds:
  - function rr_next(ptr, gnt) returning the next priority pointer;
  - function onehot_to_idx;
  - localparam MAX_NUM_REQ = 16;
  - the counter width constant PERF_CNT_WIDTH = 32.
- Sub-module rr_arbiter: parameter N, inputs req/clk_i/rst_i, outputs one-hot gnt. It is instantiated twice, once for write and once for read.

Test Plan:
- Defaults (NUM_REQ=4, RD_LATENCY=1); all four write at the same time to addresses 0x10..0x13 with data 0xA0..0xA3 and byte_valid=4'hF.
  - Grants occur in order 0,1,2,3 on consecutive cycles.
  - Reads back return 0xA0..0xA3.
- Requesters 1 and 3 hold rd_req continuously for 8 cycles.
  - Grants alternate 1,3,1,3.
  - Each rd_valid_o pulse arrives 2 cycles after its grant, carrying the correct data.
- RD_LATENCY=2, back-to-back reads of addresses 0..7 preloaded with 0x00..0x07.
  - rd_valid_o appears 3 cycles after each grant.
  - Data is 0x00..0x07 in order, with no gaps.
- Write 0xDEADBEEF to 0x20 with byte_valid=4'b0101 over a prior value of 0x11111111.
  - A later read returns 0x11AD11EF.
  - A read of 0x20 granted in the same cycle as the write returns 0x11111111.
- Assert rst_i while 2 reads are in flight.
  - All outputs go to 0 immediately.
  - No rd_valid_o appears after reset is released.
  - The next grant goes to requester 0.
- With SDP_RAM_ARB_PERF_CNT_EN: 4 requesters write for 4 cycles.
  - perf_wr_stall_o reads 3 after the last grant.
  - Without the macro it reads 0.
